// File: rtl/haraka_absorb_deser_if.sv
// haraka_absorb_deser_if
//  Stream bundle between a message source, the absorb deserializer and the
//  permutation core.
//  Input side : in_valid, in_ready, in_data[INWIDTH], in_last
//               (plus in_bytes when HARAKA_BYTE_LEN_EN is defined)
//  Output side: out_valid, out_ready, out_data[OUTWIDTH], out_last
//  Modports   : master = stream source / block sink (testbench side)
//               slave  = deserializer side
interface haraka_absorb_deser_if #(
  parameter int INWIDTH  = 64,
  parameter int OUTWIDTH = 256
);
  logic                in_valid;
  logic                in_ready;
  logic [INWIDTH-1:0]  in_data;
  logic                in_last;
`ifdef HARAKA_BYTE_LEN_EN
  localparam int BW = $clog2(INWIDTH/8) + 1;
  logic [BW-1:0]       in_bytes;
`endif
  logic                out_valid;
  logic                out_ready;
  logic [OUTWIDTH-1:0] out_data;
  logic                out_last;

  modport master (
    output in_valid, in_data, in_last,
`ifdef HARAKA_BYTE_LEN_EN
           in_bytes,
`endif
           out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last,
`ifdef HARAKA_BYTE_LEN_EN
           in_bytes,
`endif
           out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/haraka_absorb_deser.sv
// haraka_absorb_deser
//  Packs INWIDTH-bit message words into OUTWIDTH-bit rate blocks for the
//  Haraka-S absorb path and appends pad10*1 padding (PAD_BYTE first, top bit
//  of the block last) after the final word of each message.
//  Ports:
//    clk    - clock, all logic on posedge
//    rst_n  - asynchronous active-low reset
//    bus    - haraka_absorb_deser_if.slave: word input stream
//             (in_valid/in_ready/in_data/in_last[/in_bytes]) and registered
//             block output stream (out_valid/out_ready/out_data/out_last)
//  Build option HARAKA_BYTE_LEN_EN: adds in_bytes so the final word may carry
//  1..INWIDTH/8 valid bytes; padding then starts inside that word.
module haraka_absorb_deser #(
  parameter int         INWIDTH  = 64,
  parameter int         OUTWIDTH = 256,
  parameter logic [7:0] PAD_BYTE = 8'h1F
) (
  input logic                   clk,
  input logic                   rst_n,
  haraka_absorb_deser_if.slave  bus
);
  localparam int IW = INWIDTH;
  localparam int N  = OUTWIDTH / INWIDTH;
  localparam int CW = ($clog2(N) > 1) ? $clog2(N) : 1;
  localparam int NB = INWIDTH / 8;

  typedef enum logic {ST_FILL, ST_PAD} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_next;
  logic                  r_pad_first;
  logic                  w_pad_first_next;
  logic                  r_alive;       // holds in_ready low until the first edge after reset
  logic [OUTWIDTH-1:0]   r_asm;         // assembly register
  logic                  r_full;        // r_asm holds a finished block waiting for the output stage
  logic                  r_full_last;
  logic                  r_out_valid;
  logic [OUTWIDTH-1:0]   r_out_data;
  logic                  r_out_last;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_last_slot;
  logic                  w_partial;
  logic [IW-1:0]         w_in_word;
  logic [IW-1:0]         w_word;
  logic                  w_wr;
  logic                  w_done;
  logic                  w_blk_last;
  logic                  w_out_free;
  logic [OUTWIDTH-1:0]   w_blk;

  assign w_in_ready  = r_alive && (r_state == ST_FILL) && !r_full;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_last_slot = (r_cnt == CW'(N - 1));
  // The output register can take a block this cycle if empty or being drained.
  assign w_out_free  = !r_out_valid || bus.out_ready;

`ifdef HARAKA_BYTE_LEN_EN
  localparam int BW = $clog2(NB) + 1;
  // Bytes at/above in_bytes of the final word become PAD_BYTE then zeros.
  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    assign w_in_word[gi*8 +: 8] =
      (!bus.in_last || (bus.in_bytes > BW'(gi))) ? bus.in_data[gi*8 +: 8] :
      (bus.in_bytes == BW'(gi))                  ? PAD_BYTE : 8'h00;
  end
  assign w_partial = bus.in_last && (bus.in_bytes < BW'(NB));
`else
  assign w_in_word = bus.in_data;
  assign w_partial = 1'b0;
`endif

  // Block image with the current word dropped into its lane.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign w_blk[gi*IW +: IW] = (w_wr && (r_cnt == CW'(gi))) ? w_word : r_asm[gi*IW +: IW];
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_pad_first_next = r_pad_first;
    w_wr             = 1'b0;
    w_word           = '0;
    w_done           = 1'b0;
    w_blk_last       = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_accept) begin
          w_wr   = 1'b1;
          w_word = w_in_word;
          if (w_last_slot) begin
            w_done     = 1'b1;
            w_cnt_next = '0;
            if (w_partial) begin
              // Short final word already carries PAD_BYTE and closes the block.
              w_word[IW-1] = 1'b1;
              w_blk_last   = 1'b1;
            end else if (bus.in_last) begin
              // Block-aligned message: a whole pad block follows.
              w_state_next     = ST_PAD;
              w_pad_first_next = 1'b1;
            end
          end else begin
            w_cnt_next = r_cnt + CW'(1);
            if (bus.in_last) begin
              w_state_next     = ST_PAD;
              w_pad_first_next = !w_partial;
            end
          end
        end
      end
      ST_PAD: begin
        // Stall while the previous block still occupies the assembly register.
        if (!r_full) begin
          w_wr             = 1'b1;
          w_pad_first_next = 1'b0;
          if (r_pad_first) w_word[7:0] = PAD_BYTE;
          if (w_last_slot) begin
            w_word[IW-1] = 1'b1;
            w_done       = 1'b1;
            w_blk_last   = 1'b1;
            w_cnt_next   = '0;
            w_state_next = ST_FILL;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FILL;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_pad_first <= 1'b0;
      r_alive     <= 1'b0;
      r_asm       <= '0;
      r_full      <= 1'b0;
      r_full_last <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_alive     <= 1'b1;
      r_cnt       <= w_cnt_next;
      r_pad_first <= w_pad_first_next;
      if (w_done) begin
        if (w_out_free) begin
          // Completed block goes straight out: one cycle latency, no bubble.
          r_out_valid <= 1'b1;
          r_out_data  <= w_blk;
          r_out_last  <= w_blk_last;
        end else begin
          r_asm       <= w_blk;
          r_full      <= 1'b1;
          r_full_last <= w_blk_last;
        end
      end else begin
        if (w_wr) r_asm <= w_blk;
        if (r_full && w_out_free) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_asm;
          r_out_last  <= r_full_last;
          r_full      <= 1'b0;
        end else if (bus.out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_haraka_absorb_deser.sv
// tb_haraka_absorb_deser
//  Drives messages into haraka_absorb_deser and compares every output block
//  with a sponge-padding reference built from whole-message arithmetic.
module tb_haraka_absorb_deser;
  localparam int         IW  = 64;
  localparam int         OW  = 256;
  localparam int         N   = OW / IW;
  localparam int         NB  = IW / 8;
  localparam logic [7:0] PAD = 8'h1F;
`ifdef HARAKA_BYTE_LEN_EN
  localparam int         BW  = $clog2(NB) + 1;
`endif

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   stall_cnt = 0;
  int   ready_mode = 0;   // 0 random, 1 always ready, 2 held low
  int   blk_no = 0;

  logic [IW-1:0]  msg_q[$];
  logic [256:0]   exp_q[$];  // {last, data}
  int             hs_q[$];

  haraka_absorb_deser_if #(.INWIDTH(IW), .OUTWIDTH(OW)) bus ();

  haraka_absorb_deser #(.INWIDTH(IW), .OUTWIDTH(OW), .PAD_BYTE(PAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [257:0] act, input logic [257:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Reference: message words, then PAD_BYTE (inside a short last word or as a
  // new word), zero words up to a block multiple, top bit of the final word.
  task automatic expect_msg(input int nb);
    logic [IW-1:0] q[$];
    logic [IW-1:0] w;
    logic [OW-1:0] blk;
    int            nblk;
    q = msg_q;
    if (nb < NB) begin
      w = q[q.size()-1];
      for (int b = 0; b < NB; b++) begin
        if (b == nb)     w[b*8 +: 8] = PAD;
        else if (b > nb) w[b*8 +: 8] = 8'h00;
      end
      q[q.size()-1] = w;
    end else begin
      q.push_back(IW'(PAD));
    end
    while (q.size() % N != 0) q.push_back('0);
    w = q[q.size()-1];
    w[IW-1] = 1'b1;
    q[q.size()-1] = w;
    nblk = q.size() / N;
    for (int c = 0; c < nblk; c++) begin
      for (int k = 0; k < N; k++) blk[k*IW +: IW] = q[c*N + k];
      exp_q.push_back({(c == nblk - 1), blk});
    end
  endtask

  task automatic send_msg(input int nb, input int gap_pct, input int limit);
    int budget;
    for (int i = 0; i < limit; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = msg_q[i];
      bus.in_last  = (i == msg_q.size() - 1);
`ifdef HARAKA_BYTE_LEN_EN
      bus.in_bytes = (i == msg_q.size() - 1) ? BW'(nb) : BW'(NB);
`endif
      budget = 0;
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        stall_cnt++;
        budget++;
        if (budget > 300) begin
          check("in_ready_timeout", 258'(bus.in_ready), 258'(1));
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    check("drain", 258'(exp_q.size()), 258'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back({$urandom, $urandom});
  endtask

  // Output side: drives out_ready and scores every handshake.
  initial begin : monitor
    logic [256:0] e;
    logic [257:0] prev;
    bit           prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = ($urandom_range(0, 1) == 1);
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
      @(negedge clk);
      if (prev_stall && rst_n)
        check("hold_stable", {bus.out_valid, bus.out_last, bus.out_data}, prev);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev = {bus.out_valid, bus.out_last, bus.out_data};
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_blk", 258'(bus.out_valid), 258'(0));
        end else begin
          e = exp_q.pop_front();
          $display("blk %0d: last=%0b data=%h", blk_no, bus.out_last, bus.out_data);
          check("blk_data", 258'(bus.out_data), 258'(e[255:0]));
          check("blk_last", 258'(bus.out_last), 258'(e[256]));
          hs_q.push_back(cyc);
          blk_no++;
        end
      end
    end
  end

  initial begin : main
    logic [IW-1:0] a, b, c, d;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
`ifdef HARAKA_BYTE_LEN_EN
    bus.in_bytes = BW'(NB);
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 258'(bus.out_valid), 258'(0));
    check("rst_out_data",  258'(bus.out_data),  258'(0));
    check("rst_out_last",  258'(bus.out_last),  258'(0));
    check("rst_in_ready",  258'(bus.in_ready),  258'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_before_edge", 258'(bus.in_ready), 258'(0));
    @(negedge clk);
    check("rdy_after_edge", 258'(bus.in_ready), 258'(1));
    @(posedge clk);
    #1;

    // Three words, last on the third: padding shares the block.
    ready_mode = 1;
    a = 64'hA1A2A3A4A5A6A7A8; b = 64'hB1B2B3B4B5B6B7B8;
    c = 64'hC1C2C3C4C5C6C7C8; d = 64'hD1D2D3D4D5D6D7D8;
    msg_q.delete(); msg_q.push_back(a); msg_q.push_back(b); msg_q.push_back(c);
    exp_q.push_back({1'b1, 64'h800000000000001F, c, b, a});
    send_msg(NB, 0, 3);
    wait_drain();

    // Four words: full data block then a whole pad block.
    msg_q.push_back(d);
    exp_q.push_back({1'b0, d, c, b, a});
    exp_q.push_back({1'b1, 64'h8000000000000000, 64'h0, 64'h0, 64'h000000000000001F});
    send_msg(NB, 0, 4);
    wait_drain();

    // Single word message.
    msg_q.delete(); msg_q.push_back(a);
    exp_q.push_back({1'b1, 64'h8000000000000000, 64'h0, 64'h000000000000001F, a});
    send_msg(NB, 0, 1);
    wait_drain();

    // Continuous 8-word stream: no input stall, blocks N cycles apart.
    rand_msg(8);
    expect_msg(NB);
    stall_cnt = 0;
    hs_q.delete();
    send_msg(NB, 0, 8);
    check("stream_stalls", 258'(stall_cnt), 258'(0));
    wait_drain();
    if (hs_q.size() == 3) begin
      check("blk_spacing0", 258'(hs_q[1] - hs_q[0]), 258'(N));
      check("blk_spacing1", 258'(hs_q[2] - hs_q[1]), 258'(N));
    end else begin
      check("stream_blocks", 258'(hs_q.size()), 258'(3));
    end

    // Backpressure: consumer stalls, second block parks, input blocked.
    ready_mode = 2;
    rand_msg(8);
    expect_msg(NB);
    send_msg(NB, 0, 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 258'(bus.out_valid), 258'(1));
      check("bp_data",  258'(bus.out_data),  258'(exp_q[0][255:0]));
      check("bp_in_ready", 258'(bus.in_ready), 258'(0));
    end
    @(posedge clk);
    #1;
    ready_mode = 1;
    wait_drain();

    // Reset mid-message discards the partial block.
    rand_msg(4);
    send_msg(NB, 0, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 258'(bus.out_valid), 258'(0));
    check("midrst_in_ready",  258'(bus.in_ready),  258'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_msg(4);
    expect_msg(NB);
    send_msg(NB, 0, 4);
    wait_drain();

`ifdef HARAKA_BYTE_LEN_EN
    // Short final word: padding starts inside it.
    msg_q.delete(); msg_q.push_back(64'h1122334455667788);
    exp_q.push_back({1'b1, 64'h8000000000000000, 64'h0, 64'h0, 64'h000000001F667788});
    send_msg(3, 0, 1);
    wait_drain();
`endif

    // Random messages with random gaps and backpressure.
    ready_mode = 0;
    for (int m = 0; m < 14; m++) begin
      int len;
      int nb;
      len = $urandom_range(1, 9);
      nb  = NB;
`ifdef HARAKA_BYTE_LEN_EN
      nb  = $urandom_range(1, NB);
`endif
      rand_msg(len);
      expect_msg(nb);
      send_msg(nb, 30, len);
    end
    ready_mode = 1;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
